br_resolve_ctrl: RTL and testbench

- Branch resolution and redirect controller for the 5-stage RV32 pipeline.
- Consumes comparator flags (LT/LTU/EQ) from the EX-stage branch comparator and decodes funct3 into a taken/not-taken decision.
- Compares that decision with the IF-stage prediction; on mismatch, sequences the PC redirect and the IF/ID and ID/EX flush.
- Owns a 2-bit saturating branch history table (BHT) that supplies IF-stage predictions.

---
 rtl/br_resolve_ctrl_pkg.sv | 52 +++++
 rtl/br_bht.sv | 34 +++
 rtl/br_resolve_ctrl.sv | 151 +++++++++++++++
 tb/tb_br_resolve_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/br_resolve_ctrl_pkg.sv
// Shared definitions for the branch resolution controller: funct3 encodings,
// BHT counter states, FSM states and the condition/counter helper functions.
package br_resolve_ctrl_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] BHT_SNT = 2'b00;
    localparam logic [1:0] BHT_WNT = 2'b01;
    localparam logic [1:0] BHT_WT  = 2'b10;
    localparam logic [1:0] BHT_ST  = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } br_state_e;

    // Unused funct3 codes (010/011) fall to not-taken.
    function automatic logic br_cond_eval(input logic [2:0] funct3, input logic lt,
                                          input logic ltu, input logic eq);
        logic res;
        case (funct3)
            F3_BEQ:  res = eq;
            F3_BNE:  res = !eq;
            F3_BLT:  res = lt;
            F3_BGE:  res = !lt;
            F3_BLTU: res = ltu;
            F3_BGEU: res = !ltu;
            default: res = 1'b0;
        endcase
        return res;
    endfunction

    function automatic logic f3_illegal(input logic [2:0] funct3);
        return (funct3 == 3'b010) || (funct3 == 3'b011);
    endfunction

    function automatic logic [1:0] bht_next(input logic [1:0] ctr, input logic taken);
        logic [1:0] nxt;
        if (taken) begin
            nxt = (ctr == BHT_ST) ? BHT_ST : ctr + 2'd1;
        end else begin
            nxt = (ctr == BHT_SNT) ? BHT_SNT : ctr - 2'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/br_bht.sv
// Branch history table: 2-bit saturating counters with a combinational read
// port for IF and a clock-edge write port for EX resolution.
module br_bht
    import br_resolve_ctrl_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    logic [1:0] ctr_r [ENTRIES];

    // Read sees the pre-update value when the same index is written this cycle.
    assign rd_taken = ctr_r[rd_idx][1];

    // Counter array: reset to weakly not-taken, saturating update on resolution.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_r[i] <= BHT_WNT;
            end
        end else if (wr_en) begin
            ctr_r[wr_idx] <= bht_next(ctr_r[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/br_resolve_ctrl.sv
// Branch resolution and redirect controller with BHT-based IF prediction.
// Optional performance counters are enabled by defining BR_PERF_CNT_EN.
module br_resolve_ctrl
    import br_resolve_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int BHT_ENTRIES  = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] i_if_pc,
    output logic                  o_pred_taken,
    input  logic                  i_ex_valid,
    input  logic                  i_is_branch,
    input  logic                  i_is_jal,
    input  logic                  i_is_jalr,
    input  logic [2:0]            i_funct3,
    input  logic                  i_ctrl_LT,
    input  logic                  i_ctrl_LTU,
    input  logic                  i_ctrl_EQ,
    input  logic                  i_ex_pred_taken,
    input  logic [DATA_WIDTH-1:0] i_ex_pc,
    input  logic [DATA_WIDTH-1:0] i_ex_target,
    output logic                  o_redirect,
    output logic [DATA_WIDTH-1:0] o_redirect_pc,
    output logic                  o_flush,
    output logic                  o_illegal,
    output logic [31:0]           o_br_cnt,
    output logic [31:0]           o_mispred_cnt
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    br_state_e             state_r, state_nxt_s;
    logic [2:0]            flush_cnt_r, flush_cnt_nxt_s;
    logic                  resolve_s, cond_s, taken_s, mispred_s, illegal_s;
    logic                  redirect_r, flush_r, illegal_r;
    logic [DATA_WIDTH-1:0] redirect_pc_r, redirect_pc_nxt_s;
    logic                  unused_pc_bits_s;

    // Resolution decode; instructions seen while flushing are squashed.
    always_comb begin
        resolve_s = (state_r == ST_IDLE) && i_ex_valid;
        cond_s    = br_cond_eval(i_funct3, i_ctrl_LT, i_ctrl_LTU, i_ctrl_EQ);
        illegal_s = resolve_s && i_is_branch && f3_illegal(i_funct3);
        taken_s   = i_is_jal || i_is_jalr || (i_is_branch && cond_s);
        mispred_s = resolve_s && ((taken_s != i_ex_pred_taken) || i_is_jalr);
    end

    // Next-state logic for the redirect/flush sequencer.
    always_comb begin
        state_nxt_s     = state_r;
        flush_cnt_nxt_s = flush_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (mispred_s) begin
                    state_nxt_s     = ST_FLUSH;
                    flush_cnt_nxt_s = 3'(FLUSH_CYCLES - 1);
                end else begin
                    state_nxt_s     = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (flush_cnt_r == 3'd0) begin
                    state_nxt_s     = ST_IDLE;
                end else begin
                    flush_cnt_nxt_s = flush_cnt_r - 3'd1;
                end
            end
            default: begin
                state_nxt_s     = ST_IDLE;
                flush_cnt_nxt_s = 3'd0;
            end
        endcase
    end

    // Corrected fetch address; held between redirects.
    always_comb begin
        if (mispred_s) begin
            redirect_pc_nxt_s = taken_s ? i_ex_target : i_ex_pc + DATA_WIDTH'(3'd4);
        end else begin
            redirect_pc_nxt_s = redirect_pc_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_r       <= ST_IDLE;
            flush_cnt_r   <= 3'd0;
            redirect_r    <= 1'b0;
            flush_r       <= 1'b0;
            illegal_r     <= 1'b0;
            redirect_pc_r <= '0;
        end else begin
            state_r       <= state_nxt_s;
            flush_cnt_r   <= flush_cnt_nxt_s;
            redirect_r    <= mispred_s;
            flush_r       <= (state_nxt_s == ST_FLUSH);
            illegal_r     <= illegal_s;
            redirect_pc_r <= redirect_pc_nxt_s;
        end
    end

    assign o_redirect    = redirect_r;
    assign o_redirect_pc = redirect_pc_r;
    assign o_flush       = flush_r;
    assign o_illegal     = illegal_r;

    br_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .rd_idx   (i_if_pc[IDX_W+1:2]),
        .rd_taken (o_pred_taken),
        .wr_en    (resolve_s && i_is_branch),
        .wr_idx   (i_ex_pc[IDX_W+1:2]),
        .wr_taken (taken_s)
    );

    assign unused_pc_bits_s = ^{i_if_pc[DATA_WIDTH-1:IDX_W+2], i_if_pc[1:0]};

`ifdef BR_PERF_CNT_EN
    logic [31:0] br_cnt_r, mispred_cnt_r;

    // Free-running event counters, wrapping at 2^32.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            br_cnt_r      <= 32'd0;
            mispred_cnt_r <= 32'd0;
        end else begin
            if (resolve_s && i_is_branch) begin
                br_cnt_r <= br_cnt_r + 32'd1;
            end
            if (mispred_s) begin
                mispred_cnt_r <= mispred_cnt_r + 32'd1;
            end
        end
    end

    assign o_br_cnt      = br_cnt_r;
    assign o_mispred_cnt = mispred_cnt_r;
`else
    assign o_br_cnt      = 32'd0;
    assign o_mispred_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Self-checking bench for br_resolve_ctrl: a reference model pushes expected
// post-edge outputs to a scoreboard queue, popped and compared after the edge.
module tb_br_resolve_ctrl;

    localparam int FLUSH_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = 32'd0;
    logic        pred_taken;
    logic        ex_valid = 1'b0, is_branch = 1'b0, is_jal = 1'b0, is_jalr = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic        c_lt = 1'b0, c_ltu = 1'b0, c_eq = 1'b0, ex_pred = 1'b0;
    logic [31:0] ex_pc = 32'd0, ex_tgt = 32'd0;
    logic        redirect, flush, illegal;
    logic [31:0] redirect_pc, br_cnt, mispred_cnt;

    br_resolve_ctrl #(
        .DATA_WIDTH   (32),
        .BHT_ENTRIES  (16),
        .FLUSH_CYCLES (FLUSH_CYCLES)
    ) dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_if_pc         (if_pc),
        .o_pred_taken    (pred_taken),
        .i_ex_valid      (ex_valid),
        .i_is_branch     (is_branch),
        .i_is_jal        (is_jal),
        .i_is_jalr       (is_jalr),
        .i_funct3        (funct3),
        .i_ctrl_LT       (c_lt),
        .i_ctrl_LTU      (c_ltu),
        .i_ctrl_EQ       (c_eq),
        .i_ex_pred_taken (ex_pred),
        .i_ex_pc         (ex_pc),
        .i_ex_target     (ex_tgt),
        .o_redirect      (redirect),
        .o_redirect_pc   (redirect_pc),
        .o_flush         (flush),
        .o_illegal       (illegal),
        .o_br_cnt        (br_cnt),
        .o_mispred_cnt   (mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic [31:0] if_pc;
        logic        valid, br, jal, jalr;
        logic [2:0]  f3;
        logic        lt, ltu, eq, pred;
        logic [31:0] pc, tgt;
    } stim_t;

    typedef struct packed {
        logic        redirect, flush, illegal;
        logic [31:0] rpc, brc, mpc;
    } exp_t;

    exp_t        sb_q[$];
    logic [1:0]  m_bht [16];
    int          m_busy;
    logic [31:0] m_rpc, m_brc, m_mpc;
    int          err_cnt = 0;
    int          chk_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic stim_t mk(input logic valid, input logic br, input logic jal,
                                 input logic jalr, input logic [2:0] f3, input logic lt,
                                 input logic ltu, input logic eq, input logic pred,
                                 input logic [31:0] pc, input logic [31:0] tgt,
                                 input logic [31:0] ipc);
        stim_t s;
        s.rst_n = 1'b1; s.if_pc = ipc; s.valid = valid; s.br = br; s.jal = jal;
        s.jalr = jalr; s.f3 = f3; s.lt = lt; s.ltu = ltu; s.eq = eq; s.pred = pred;
        s.pc = pc; s.tgt = tgt;
        return s;
    endfunction

    function automatic stim_t idle(input logic [31:0] ipc);
        return mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, ipc);
    endfunction

    // Reference decode: funct3[2:1] picks the flag, funct3[0] inverts it.
    function automatic logic ref_cond(input logic [2:0] f3, input logic lt,
                                      input logic ltu, input logic eq);
        logic base;
        case (f3[2:1])
            2'b00:   base = eq;
            2'b10:   base = lt;
            2'b11:   base = ltu;
            default: return 1'b0;
        endcase
        return base ^ f3[0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_bht[i] = 2'b01;
        m_busy = 0; m_rpc = 32'd0; m_brc = 32'd0; m_mpc = 32'd0;
    endtask

    task automatic step(input stim_t s);
        exp_t e;
        logic taken, mis;
        int   wi;
        @(negedge clk);
        rst_n = s.rst_n; if_pc = s.if_pc; ex_valid = s.valid; is_branch = s.br;
        is_jal = s.jal; is_jalr = s.jalr; funct3 = s.f3; c_lt = s.lt; c_ltu = s.ltu;
        c_eq = s.eq; ex_pred = s.pred; ex_pc = s.pc; ex_tgt = s.tgt;
        #1;
        check_val("pred_taken", {31'd0, pred_taken}, {31'd0, m_bht[s.if_pc[5:2]][1]});
        e = '0;
        if (!s.rst_n) begin
            model_reset();
        end else if (m_busy > 0) begin
            m_busy--;
            e.flush = (m_busy > 0);
        end else if (s.valid) begin
            taken = s.jal | s.jalr | (s.br & ref_cond(s.f3, s.lt, s.ltu, s.eq));
            mis   = (taken != s.pred) | s.jalr;
            e.illegal = s.br && (s.f3[2:1] == 2'b01);
            if (s.br) begin
                wi = int'(s.pc[5:2]);
                if (taken && m_bht[wi] != 2'b11) m_bht[wi] = m_bht[wi] + 2'd1;
                if (!taken && m_bht[wi] != 2'b00) m_bht[wi] = m_bht[wi] - 2'd1;
                m_brc++;
            end
            if (mis) begin
                e.redirect = 1'b1;
                e.flush    = 1'b1;
                m_rpc      = taken ? s.tgt : s.pc + 32'd4;
                m_busy     = FLUSH_CYCLES;
                m_mpc++;
            end
        end
        e.rpc = m_rpc;
`ifdef BR_PERF_CNT_EN
        e.brc = m_brc; e.mpc = m_mpc;
`else
        e.brc = 32'd0; e.mpc = 32'd0;
`endif
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check_val("redirect", {31'd0, redirect}, {31'd0, e.redirect});
        check_val("flush", {31'd0, flush}, {31'd0, e.flush});
        check_val("illegal", {31'd0, illegal}, {31'd0, e.illegal});
        check_val("redirect_pc", redirect_pc, e.rpc);
        check_val("br_cnt", br_cnt, e.brc);
        check_val("mispred_cnt", mispred_cnt, e.mpc);
    endtask

    initial begin
        stim_t s;
        logic [2:0] rf3;
        int kind;
        model_reset();
        repeat (2) @(posedge clk);
        s = idle(32'h0); s.rst_n = 1'b0;
        step(s);
        step(idle(32'h100));

        // BEQ taken, predicted not-taken: redirect to target, two flush cycles.
        step(mk(1, 1, 0, 0, 3'b000, 0, 0, 1, 0, 32'h100, 32'h140, 32'h100));
        step(idle(32'h100));
        step(idle(32'h100));
        step(idle(32'h100));

        // BLT not taken, correctly predicted: BHT[0] walks down and saturates.
        for (int i = 0; i < 3; i++) begin
            step(mk(1, 1, 0, 0, 3'b100, 0, 1, 0, 0, 32'h200, 32'h280, 32'h200));
        end
        step(idle(32'h200));

        // JALR always redirects; a BNE during flush is squashed.
        step(mk(1, 0, 0, 1, 3'b000, 0, 0, 0, 1, 32'h400, 32'h3000, 32'h0));
        step(mk(1, 1, 0, 0, 3'b001, 0, 0, 0, 0, 32'h500, 32'h600, 32'h500));
        step(mk(1, 1, 0, 0, 3'b001, 0, 0, 0, 0, 32'h500, 32'h600, 32'h500));
        step(idle(32'h500));

        // Illegal funct3 at top of address space: fall-through wraps to 0.
        step(mk(1, 1, 0, 0, 3'b010, 1, 1, 1, 1, 32'hFFFF_FFFC, 32'h10, 32'hFFFF_FFFC));
        step(idle(32'hFFFF_FFFC));
        step(idle(32'hFFFF_FFFC));

        // Same-index read during update sees the old counter.
        step(mk(1, 1, 0, 0, 3'b000, 0, 0, 1, 0, 32'h104, 32'h180, 32'h104));
        step(idle(32'h104));
        step(idle(32'h104));

        // Reset during the second flush cycle.
        step(mk(1, 1, 0, 0, 3'b110, 0, 1, 0, 0, 32'h108, 32'h1C0, 32'h108));
        step(idle(32'h108));
        s = idle(32'h108); s.rst_n = 1'b0;
        step(s);
        for (int i = 0; i < 16; i++) step(idle(32'(i * 4)));

        // Random mix of control transfers.
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 5);
            rf3  = 3'($urandom_range(0, 7));
            s = mk(1'b1, kind >= 3, kind == 1, kind == 2, rf3, 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), {26'($urandom_range(0, 63)), 6'($urandom_range(0, 15) * 4)},
                   $urandom & 32'hFFFF_FFFC, 32'($urandom_range(0, 15) * 4));
            if (kind == 0) s.valid = 1'b0;
            step(s);
        end

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
